// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared defaults and counter-width helper for the input
// conditioning (synchronise + debounce) stage.
`default_nettype none

package input_cond_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_PRESCALE     = 1000;
  localparam int DEF_STABLE_TICKS = 4;

  // $clog2 clamped to at least one bit so degenerate counts still get a register.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : input_cond_pkg

`default_nettype wire

// File: rtl/debounce_bit.sv
// debounce_bit: one input lane -- synchroniser chain, stability counter,
// clean level register and rise/fall strobes.
`default_nettype none

module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  input  logic ena_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // The synchroniser runs regardless of ena so resuming sees a settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i && ena_i) begin
      if (sync_w == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
        cnt_d   = '0;
        clean_d = sync_w;
        rise_d  = sync_w;
        fall_d  = ~sync_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q & ena_i;
  assign fall_o  = fall_q & ena_i;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/input_debouncer.sv
// input_debouncer: WIDTH-lane synchroniser/debouncer sharing one sample-rate
// prescaler; emits clean levels plus single-cycle rise/fall strobes.
`default_nettype none

module input_debouncer
  import input_cond_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             tick
);

  localparam int PW = cnt_width(PRESCALE);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (ena) begin
      if (pre_q == PW'(PRESCALE - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  // A tick registered just before ena falls must not leak out while frozen.
  assign tick = tick_q & ena;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_in[i]),
      .tick_i (tick_q),
      .ena_i  (ena),
      .clean_o(clean_out[i]),
      .rise_o (rise_pulse[i]),
      .fall_o (fall_pulse[i])
    );
  end

endmodule : input_debouncer

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: vector table plus directed corner sequences; pulse
// events are checked against a scoreboard queue of expected strobes.
`default_nettype none

module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] raw_in;
  logic [7:0] clean_out;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];

  input_debouncer #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .PRESCALE    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if ((rise_pulse | fall_pulse) != 8'h00) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: clean=%h rise=%h fall=%h, no strobe expected",
                 clean_out, rise_pulse, fall_pulse);
      end else begin
        e = sb.pop_front();
        if (clean_out !== e.clean || rise_pulse !== e.rise || fall_pulse !== e.fall) begin
          n_fail++;
          $display("FAIL sb_pulse: got clean=%h rise=%h fall=%h, want clean=%h rise=%h fall=%h",
                   clean_out, rise_pulse, fall_pulse, e.clean, e.rise, e.fall);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Waits for clean_out to move from prev to exp; latency counted in negedges.
  task automatic measure(input string name, input logic [7:0] prev, input logic [7:0] exp,
                         input int lo, input int hi);
    int  k;
    bit  done;
    bit  bad;
    k    = 0;
    done = 1'b0;
    bad  = 1'b0;
    while (!done && !bad && k < 40) begin
      @(negedge clk);
      k++;
      if (clean_out === exp) done = 1'b1;
      else if (clean_out !== prev) bad = 1'b1;
    end
    n_checks++;
    if (!done || k < lo || k > hi) begin
      n_fail++;
      $display("FAIL %s: clean=%h after %0d cycles, want %h within %0d..%0d cycles",
               name, clean_out, k, exp, lo, hi);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 50);
    if (tick !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, want 1", tick, n);
    end
  endtask

  initial begin
    int         n;
    logic [7:0] prev;

    tbl[0] = '{raw: 8'h00, clean: 8'h00, rise: 8'h00, fall: 8'hFF};
    tbl[1] = '{raw: 8'h01, clean: 8'h01, rise: 8'h01, fall: 8'h00};
    tbl[2] = '{raw: 8'h0F, clean: 8'h0F, rise: 8'h0E, fall: 8'h00};
    tbl[3] = '{raw: 8'hF0, clean: 8'hF0, rise: 8'hF0, fall: 8'h0F};
    tbl[4] = '{raw: 8'hA5, clean: 8'hA5, rise: 8'h05, fall: 8'h50};
    tbl[5] = '{raw: 8'h5A, clean: 8'h5A, rise: 8'h5A, fall: 8'hA5};
    tbl[6] = '{raw: 8'h00, clean: 8'h00, rise: 8'h00, fall: 8'h5A};

    // Reset values and first qualification after release
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 8'hFF;
    repeat (5) @(negedge clk);
    check("reset_clean", {8'h00, clean_out}, 16'h0000);
    check("reset_pulses", {rise_pulse, fall_pulse}, 16'h0000);
    check("reset_tick", {15'h0, tick}, 16'h0000);
    sb.push_back('{clean: 8'hFF, rise: 8'hFF, fall: 8'h00});
    rst_n = 1'b1;
    measure("release_qualify", 8'h00, 8'hFF, 11, 15);
    @(negedge clk);
    check("release_pulse_clear", {rise_pulse, fall_pulse}, 16'h0000);
    prev = 8'hFF;

    // Vector table: includes single-bit edge and simultaneous multi-bit swap
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{clean: tbl[i].clean, rise: tbl[i].rise, fall: tbl[i].fall});
      raw_in = tbl[i].raw;
      measure($sformatf("vec%0d_latency", i), prev, tbl[i].clean, 11, 15);
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), {8'h00, clean_out}, {8'h00, tbl[i].clean});
      prev = tbl[i].clean;
    end

    // Bounce on bit 3: 2 high samples, 1 low, then 3 high
    sb.push_back('{clean: 8'h08, rise: 8'h08, fall: 8'h00});
    wait_tick(n);
    raw_in = 8'h08;
    repeat (8) @(negedge clk);
    raw_in = 8'h00;
    repeat (4) @(negedge clk);
    check("bounce_no_early", {8'h00, clean_out}, 16'h0000);
    raw_in = 8'h08;
    repeat (12) @(negedge clk);
    check("bounce_before_3rd", {8'h00, clean_out}, 16'h0000);
    @(negedge clk);
    check("bounce_accept", {8'h00, clean_out}, 16'h0008);

    // ena freeze after 2 qualifying samples
    sb.push_back('{clean: 8'h00, rise: 8'h00, fall: 8'h08});
    wait_tick(n);
    raw_in = 8'h00;
    repeat (9) @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("freeze_c%0d", i), {7'h0, tick, clean_out}, 16'h0008);
    end
    ena = 1'b1;
    wait_tick(n);
    check("resume_tick_phase", n[15:0], 16'd3);
    check("resume_before_edge", {8'h00, clean_out}, 16'h0008);
    @(negedge clk);
    check("resume_accept", {8'h00, clean_out}, 16'h0000);

    // Async reset part-way through a qualification
    sb.push_back('{clean: 8'h0F, rise: 8'h0F, fall: 8'h00});
    raw_in = 8'h0F;
    measure("pre_reset_settle", 8'h00, 8'h0F, 11, 15);
    wait_tick(n);
    raw_in = 8'hF0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clean", {8'h00, clean_out}, 16'h0000);
    check("async_reset_pulse", {rise_pulse, fall_pulse}, 16'h0000);
    repeat (2) @(negedge clk);
    sb.push_back('{clean: 8'hF0, rise: 8'hF0, fall: 8'h00});
    rst_n = 1'b1;
    measure("requalify_after_reset", 8'h00, 8'hF0, 11, 15);
    repeat (3) @(negedge clk);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d strobes outstanding, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_debouncer

`default_nettype wire
